oport_credit_buffer: RTL and testbench
======================================

Name: oport_credit_buffer

Overview:
- Credit-based receive buffer that sits directly downstream of a switch/FU ff_stage at a DySER output port.
- Accepts valid/data beats from the ff_stage under the single-credit protocol and returns a credit pulse when a slot is reserved.
- Queues up to DEPTH words and drains them to the processor-side output interface with a ready/valid handshake.
- Decouples fabric timing from processor consumption, so the ff_stage is never stalled while buffer space remains.

Parameters:
- ID, 0, instance identifier; debug only, no functional effect.
- DEPTH, 4, number of buffer entries; power of two, ≥2.
- AW, 2, log2(DEPTH); pointer width.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset; asynchronous, active-low: state clears while rst==0.
- valid_in  input  1  single-cycle beat from the upstream ff_stage valid_out.
- data_in  input  `PATH_WIDTH  data from the upstream ff_stage data_out; sampled when valid_in==1.
- credit_out  output  1  single-cycle credit pulse to the upstream ff_stage credit_in.
- out_valid  output  1  head entry available to the processor.
- out_data  output  `PATH_WIDTH  head entry data.
- out_ready  input  1  processor accepts the head entry.
- level  output  AW+1  current occupancy, 0..DEPTH.
- proto_err  output  1  sticky flag: valid_in arrived with no credit outstanding.

Behaviour:
- Reset (rst==0, async):
  - count=0, rd_ptr=wr_ptr=0, credit_out=0, proto_err=0.
  - outstanding=1: the upstream ff_stage leaves reset in its credit-held state, so one credit is implicitly granted.
  - Storage contents are don't-care.
- outstanding is a 1-bit register counting credits held upstream. Invariant: count + outstanding ≤ DEPTH at all times.
- accept = valid_in & outstanding.
  - On accept, data_in is written at wr_ptr and wr_ptr increments, wrapping mod DEPTH.
- valid_in while outstanding==0 is a protocol error:
  - The beat is dropped; no write, no count change.
  - proto_err is set next cycle and stays set until reset.
- pop = out_valid & out_ready; rd_ptr increments, wrapping mod DEPTH.
- out_valid = (count!=0); out_data = mem[rd_ptr]. Both are combinational from registers; no bypass.
- count_next = count + accept - pop. Simultaneous accept and pop leaves count unchanged, including at count==DEPTH-1.
- Credit issue, evaluated every cycle:
  - o_after = outstanding - accept.
  - issue = (o_after==0) & (count_next < DEPTH).
  - credit_out <= issue (registered, one-cycle pulse); outstanding <= o_after | issue.
- Latency:
  - valid_in at cycle t → out_valid at t+1 if the buffer was empty.
  - credit_out at t+1 if space remains after the accept.
- Full condition: when accept brings count_next to DEPTH, no credit is issued and credit is owed.
  - The credit is issued in the cycle after the first pop, registered: pop at t → credit_out at t+1.
- credit_out never asserts in consecutive cycles, because outstanding must drop back to 0 via an accept first.
- level = count. count saturates by construction; overflow is impossible because accept requires outstanding==1.
- Reset asserted mid-operation discards all queued data. outstanding returns to 1, consistent with the upstream ff_stage also being reset.

Decomposition:
- Shared package / config.v: `PATH_WIDTH (existing); add `OPORT_DEPTH default and `OPORT_CREDIT_INIT (=1) constants.
- One natural sub-module: oport_buf_mem, a DEPTH×`PATH_WIDTH register file with one write port and one asynchronous read port.
- Pointer, count and credit logic stay in oport_credit_buffer.

Test Plan:
- Reset, then a single beat: release rst, valid_in=1 with data 0x2A at cycle 3 → credit_out=1 at cycle 4; out_valid=1, out_data=0x2A, level=1 at cycle 4.
- Fill, DEPTH=4, out_ready=0: beats 1,2,3,4 each sent one cycle after the previous credit → credits after beats 1–3 only; level=4; no credit after beat 4.
- Owed credit: from the full state, out_ready=1 for one cycle at t → pop of value 1, credit_out=1 at t+1, level=3. Draining the rest yields order 2,3,4.
- Simultaneous accept and pop at level=2 → level stays 2, credit_out pulses next cycle, FIFO order preserved across pointer wrap. Run for 3×DEPTH beats.
- Protocol error: drive valid_in twice without an intervening credit → second beat dropped, level unchanged, proto_err=1 next cycle and held.
- Async reset mid-stream at level=3: pull rst low between clock edges → outputs clear immediately. After release, a new beat is accepted without any prior credit_out.

Source files
------------

// File: rtl/oport_credit_buffer_pkg.sv
// Shared configuration for the DySER output-port credit buffer.
// Datapath width, default depth and the credit held upstream out of reset.
package oport_credit_buffer_pkg;

  localparam int PATH_WIDTH = 16;
  localparam int OPORT_DEPTH = 4;
  localparam logic OPORT_CREDIT_INIT = 1'b1;

  typedef logic [PATH_WIDTH-1:0] path_t;

endpackage

// File: rtl/oport_buf_mem.sv
// DEPTH x PATH_WIDTH register file: one synchronous write port, one
// asynchronous read port so the head entry is visible in the same cycle.
module oport_buf_mem
  import oport_credit_buffer_pkg::*;
#(
  parameter int DEPTH = OPORT_DEPTH,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  path_t         i_wdata,
  input  logic [AW-1:0] i_raddr,
  output path_t         o_rdata
);

  // Contents are never reset; occupancy tracking makes stale entries invisible.
  path_t r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/oport_credit_buffer.sv
// Credit-based receive buffer between a fabric ff_stage and the processor
// output interface; grants one credit at a time while buffer space remains.
module oport_credit_buffer
  import oport_credit_buffer_pkg::*;
#(
  parameter int ID    = 0,
  parameter int DEPTH = OPORT_DEPTH,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_valid_in,
  input  path_t         i_data_in,
  output logic          o_credit_out,
  output logic          o_out_valid,
  output path_t         o_out_data,
  input  logic          i_out_ready,
  output logic [AW:0]   o_level,
  output logic          o_proto_err
);

  logic [AW:0]   r_count;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic          r_outstanding;
  logic          r_credit;
  logic          r_proto_err;

  logic          w_accept;
  logic          w_pop;
  logic [AW:0]   w_count_next;
  logic          w_o_after;
  logic          w_issue;
  logic          w_unused_id;

  assign w_unused_id = ^ID;

  assign o_out_valid  = (r_count != '0);
  assign w_accept     = i_valid_in & r_outstanding;
  assign w_pop        = o_out_valid & i_out_ready;
  assign w_count_next = r_count + (AW+1)'(w_accept) - (AW+1)'(w_pop);

  // A new credit is only granted once the previous one has been spent and the
  // slot it would reserve actually exists after this cycle's traffic.
  assign w_o_after = r_outstanding & ~w_accept;
  assign w_issue   = ~w_o_after & (w_count_next < (AW+1)'(DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count       <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_outstanding <= OPORT_CREDIT_INIT;
      r_credit      <= 1'b0;
      r_proto_err   <= 1'b0;
    end else begin
      r_count       <= w_count_next;
      r_credit      <= w_issue;
      r_outstanding <= w_o_after | w_issue;
      if (w_accept) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)    r_rd_ptr <= r_rd_ptr + 1'b1;
      // A beat with no credit outstanding is dropped and flagged until reset.
      if (i_valid_in & ~r_outstanding) r_proto_err <= 1'b1;
    end
  end

  oport_buf_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_accept),
    .i_waddr (r_wr_ptr),
    .i_wdata (i_data_in),
    .i_raddr (r_rd_ptr),
    .o_rdata (o_out_data)
  );

  assign o_credit_out = r_credit;
  assign o_level      = r_count;
  assign o_proto_err  = r_proto_err;

endmodule

// File: tb/tb_oport_credit_buffer.sv
// Scoreboard bench for oport_credit_buffer: a queue-based reference model
// predicts per-cycle credit/level/error and the order of drained words.
module tb_oport_credit_buffer;
  import oport_credit_buffer_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_valid_in = 1'b0;
  path_t       i_data_in = '0;
  logic        i_out_ready = 1'b0;
  logic        o_credit_out;
  logic        o_out_valid;
  path_t       o_out_data;
  logic [AW:0] o_level;
  logic        o_proto_err;

  oport_credit_buffer #(.ID(0), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_valid_in   (i_valid_in),
    .i_data_in    (i_data_in),
    .o_credit_out (o_credit_out),
    .o_out_valid  (o_out_valid),
    .o_out_data   (o_out_data),
    .i_out_ready  (i_out_ready),
    .o_level      (o_level),
    .o_proto_err  (o_proto_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        credit;
    logic [AW:0] level;
    logic        proto;
  } exp_t;

  exp_t  exp_state_q[$];
  path_t exp_data_q[$];
  int    checks = 0;
  int    errors = 0;

  // Model state: credits held by the fabric side, sticky error, and the
  // upstream sender's view (a credit seen in cycle t is usable from t+1).
  bit m_out = 1'b1;
  bit m_proto = 1'b0;
  bit up_credit = 1'b1;
  bit up_pend = 1'b0;
  bit prev_credit = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // State monitor: registered outputs just after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_state_q.size() > 0) begin
        e = exp_state_q.pop_front();
        check("credit_out", 32'(o_credit_out), 32'(e.credit));
        check("level", 32'(o_level), 32'(e.level));
        check("proto_err", 32'(o_proto_err), 32'(e.proto));
        check("out_valid", 32'(o_out_valid), 32'(e.level != 0));
        check("credit_gap", 32'(prev_credit & o_credit_out), 32'd0);
        $display("cyc t=%0t credit=%0b level=%0d proto=%0b", $time, o_credit_out, o_level, o_proto_err);
      end
      prev_credit = o_credit_out;
    end
  end

  // Data monitor: every handshake pops the oldest accepted word.
  initial begin
    path_t w;
    forever begin
      @(negedge clk);
      if (rst_n && o_out_valid && i_out_ready) begin
        if (exp_data_q.size() == 0) begin
          check("data_underflow", 32'd1, 32'd0);
        end else begin
          w = exp_data_q.pop_front();
          check("out_data", 32'(o_out_data), 32'(w));
          $display("pop data=%0h expected=%0h", o_out_data, w);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
    if (up_pend) up_credit = 1'b1;
    up_pend = o_credit_out;
  endtask

  task automatic drive(input logic v, input path_t d, input logic r);
    int   occ;
    logic acc;
    logic pop;
    logic cr;
    exp_t e;
    i_valid_in  = v;
    i_data_in   = d;
    i_out_ready = r;
    if (v) up_credit = 1'b0;
    occ = exp_data_q.size();
    acc = v && m_out;
    pop = (occ != 0) && r;
    if (v && !m_out) m_proto = 1'b1;
    if (acc) exp_data_q.push_back(d);
    occ = occ + int'(acc) - int'(pop);
    if (acc) m_out = 1'b0;
    cr = !m_out && (occ < DEPTH);
    if (cr) m_out = 1'b1;
    e.credit = cr;
    e.level  = (AW+1)'(occ);
    e.proto  = m_proto;
    exp_state_q.push_back(e);
  endtask

  task automatic step(input logic v, input path_t d, input logic r);
    tick();
    drive(v, d, r);
  endtask

  task automatic send(input path_t d, input logic r_send, input logic r_idle);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (up_credit) begin
        drive(1'b1, d, r_send);
        return;
      end
      drive(1'b0, '0, r_idle);
    end
    check("send_timeout", 32'd1, 32'd0);
  endtask

  // Asynchronous reset pulled between clock edges.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    i_valid_in = 1'b0;
    i_out_ready = 1'b0;
    exp_state_q.delete();
    exp_data_q.delete();
    m_out = 1'b1;
    m_proto = 1'b0;
    up_credit = 1'b1;
    up_pend = 1'b0;
    #1;
    check("rst_level", 32'(o_level), 32'd0);
    check("rst_valid", 32'(o_out_valid), 32'd0);
    check("rst_credit", 32'(o_credit_out), 32'd0);
    check("rst_proto", 32'(o_proto_err), 32'd0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    @(posedge clk);
    #1;
    check("init_level", 32'(o_level), 32'd0);
    check("init_valid", 32'(o_out_valid), 32'd0);
    check("init_credit", 32'(o_credit_out), 32'd0);
    check("init_proto", 32'(o_proto_err), 32'd0);
    #6;
    rst_n = 1'b1;

    // Single beat: visible and credited one cycle later.
    step(1'b0, '0, 1'b0);
    send(16'h002A, 1'b0, 1'b0);
    tick();
    check("single_credit", 32'(o_credit_out), 32'd1);
    check("single_data", 32'(o_out_data), 32'h2A);
    check("single_level", 32'(o_level), 32'd1);
    drive(1'b0, '0, 1'b0);
    repeat (3) step(1'b0, '0, 1'b1);

    // Fill with no drain; credit owed after the fourth beat.
    for (int k = 1; k <= DEPTH; k++) send(path_t'(k), 1'b0, 1'b0);
    tick();
    check("full_level", 32'(o_level), 32'd4);
    check("full_no_credit", 32'(o_credit_out), 32'd0);
    drive(1'b0, '0, 1'b0);
    repeat (3) step(1'b0, '0, 1'b0);

    // One pop releases the owed credit next cycle.
    step(1'b0, '0, 1'b1);
    tick();
    check("owed_credit", 32'(o_credit_out), 32'd1);
    check("owed_level", 32'(o_level), 32'd3);
    drive(1'b0, '0, 1'b0);
    repeat (5) step(1'b0, '0, 1'b1);

    // Steady state at level 2 with simultaneous accept and pop.
    send(16'h0020, 1'b0, 1'b0);
    send(16'h0021, 1'b0, 1'b0);
    for (int i = 0; i < 3 * DEPTH; i++) send(path_t'(16'h0100 + i), 1'b1, 1'b0);
    tick();
    check("steady_level", 32'(o_level), 32'd2);
    drive(1'b0, '0, 1'b1);
    repeat (4) step(1'b0, '0, 1'b1);

    // Protocol error: a beat while full with no credit is dropped.
    for (int k = 0; k < DEPTH; k++) send(path_t'(16'h0A0 + k), 1'b0, 1'b0);
    step(1'b1, 16'h0BAD, 1'b0);
    tick();
    check("perr_flag", 32'(o_proto_err), 32'd1);
    check("perr_level", 32'(o_level), 32'd4);
    drive(1'b0, '0, 1'b0);
    repeat (2) step(1'b0, '0, 1'b1);
    repeat (2) step(1'b0, '0, 1'b0);
    do_reset();

    // Randomized traffic against the model.
    repeat (300) begin
      tick();
      drive(up_credit && ($urandom_range(0, 1) == 1), path_t'($urandom), 1'($urandom_range(0, 1)));
    end
    repeat (6) step(1'b0, '0, 1'b1);

    // Async reset at level 3, then a beat with no prior credit pulse.
    for (int k = 0; k < 3; k++) send(path_t'(16'h0030 + k), 1'b0, 1'b0);
    tick();
    check("pre_rst_level", 32'(o_level), 32'd3);
    drive(1'b0, '0, 1'b0);
    do_reset();
    send(16'h0055, 1'b0, 1'b0);
    tick();
    check("post_rst_valid", 32'(o_out_valid), 32'd1);
    check("post_rst_data", 32'(o_out_data), 32'h55);
    drive(1'b0, '0, 1'b1);

    repeat (150) begin
      tick();
      drive(up_credit && ($urandom_range(0, 2) != 0), path_t'($urandom), 1'($urandom_range(0, 1)));
    end
    repeat (6) step(1'b0, '0, 1'b1);
    tick();
    check("final_empty", 32'(o_level), 32'd0);
    drive(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
